bus_addr_ctrl: RTL and testbench
================================

Name: bus_addr_ctrl

Overview:
- Parametrised, registered bus address decoder and access controller for the 11_BUS subsystem.
- One master issues a request with an address. The block decodes the address into a one-hot slave select over NUM_SLAVES equal windows, holds the select until the chosen slave acknowledges, and aborts with an error on a timeout or an unmapped address.
- It replaces the fixed two-slave combinational decode. With default parameters the address map is unchanged: 0x00-0x1F selects slave 0, 0x20-0x3F selects slave 1, and 0x40 and above is unmapped.

Parameters:
ADDR_W, 8, master address width
WIN_BITS, 5, log2 of the slave window size; the slave offset is the low WIN_BITS bits of the address
NUM_SLAVES, 2, number of slave windows; legal range 1..2^(ADDR_W-WIN_BITS)
TIMEOUT, 16, maximum ACCESS cycles without an acknowledge; must be at least 1
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
m_req  in  1  master request; sampled only in IDLE
m_address  in  ADDR_W  master address; sampled with m_req
m_wr  in  1  1 = write, 0 = read; sampled with m_req
m_busy  out  1  high while in ACCESS
m_done  out  1  one-cycle pulse marking the end of every accepted request
m_err  out  1  valid with m_done; 1 = unmapped address or timeout
s_sel  out  NUM_SLAVES  one-hot slave select; all zero when not in ACCESS
s_offset  out  WIN_BITS  latched address offset; valid while s_sel is non-zero
s_wr  out  1  latched m_wr; valid while s_sel is non-zero
s_ack  in  NUM_SLAVES  per-slave acknowledge
err_cnt  out  CNT_W  saturating count of error completions

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; m_busy, m_done, m_err, s_wr, s_sel, s_offset, err_cnt, timer all 0.
- State encoding: IDLE and ACCESS only. m_done is a pulse generated on the ACCESS-to-IDLE transition, or directly from IDLE for an unmapped address.
- Decode: idx = m_address >> WIN_BITS. The request hits when idx < NUM_SLAVES.
- IDLE with m_req=1 in cycle T:
  - Hit: latch idx, offset and m_wr. In cycle T+1: s_sel = 1<<idx, m_busy=1, state ACCESS, timer=0.
  - Miss: state stays IDLE. In cycle T+1: m_done=1, m_err=1, err_cnt incremented; s_sel never asserts.
- ACCESS, each cycle:
  - If s_ack[idx]=1: next cycle m_done=1, m_err=0, s_sel=0, m_busy=0, state IDLE.
  - Else if timer==TIMEOUT-1: next cycle m_done=1, m_err=1, s_sel=0, m_busy=0, state IDLE, err_cnt incremented.
  - Else: timer increments.
- ACCESS therefore lasts at most TIMEOUT cycles. When s_sel first rises in T+1, a timeout completes with m_done at T+1+TIMEOUT.
- Acknowledge has priority over timeout in the same cycle.
- s_ack bits of non-selected slaves are ignored in all states. s_ack in IDLE is ignored.
- m_req in ACCESS is ignored and not queued. The master must hold or re-issue the request.
- Back-to-back: the state is IDLE in the m_done cycle, so an m_req in that cycle is accepted. Minimum spacing is 2 cycles for a hit with an immediate ack.
- err_cnt saturates at 2^CNT_W-1 and is cleared only by reset.
- Reset mid-ACCESS: the next cycle gives s_sel=0 and IDLE, with no m_done.

Decomposition:
- Shared package/include (bus_pkg):
  - state localparams ST_IDLE and ST_ACCESS.
  - clog2 function used for the idx width, max(1, clog2(NUM_SLAVES)).
  - Default map constants ADDR_W=8 and WIN_BITS=5, shared with the other BUS blocks.
- One sub-module: bus_addr_map. It is combinational, takes the address and outputs idx and hit. It is parametrised identically and is reusable by the arbiter.

Test Plan:
- m_req with 0x1F, s_ack=2'b01 two cycles after s_sel rises: s_sel=2'b01 with s_offset=0x1F; m_done=1, m_err=0 one cycle after the ack; s_sel=0 with it.
- m_req with 0x2F and m_wr=1, immediate ack: s_sel=2'b10, s_offset=0x0F, s_wr=1. A second request 0x05 issued in the m_done cycle is accepted, and s_sel=2'b01 in the next cycle.
- m_req with 0x55: s_sel stays 0; m_done=1, m_err=1 one cycle after the request; err_cnt=1.
- m_req with 0x11, no ack, TIMEOUT=16: s_sel=2'b01 for exactly 16 cycles; then m_done=1, m_err=1, err_cnt increments. Also cover s_ack=2'b10 during this access: it is ignored.
- Ack on the last ACCESS cycle (cycle 16): m_err=0. m_req=1 with 0x39 while busy: no effect.
- Assert reset while s_sel=2'b10: next cycle all outputs are 0 and no m_done occurs. Separately, force 300 unmapped requests: err_cnt saturates at 255.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared BUS-subsystem definitions: controller states, default address map,
// and width helpers used by the decoder, the controller and the arbiter.
package bus_pkg;

  localparam int BUS_ADDR_W   = 8;
  localparam int BUS_WIN_BITS = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_ctrl_if.sv
// Master-side request/response and slave-side select/ack bundle of the
// address controller.
interface bus_addr_ctrl_if #(
  parameter int ADDR_W     = bus_pkg::BUS_ADDR_W,
  parameter int WIN_BITS   = bus_pkg::BUS_WIN_BITS,
  parameter int NUM_SLAVES = 2,
  parameter int CNT_W      = 8
);
  logic                  m_req;
  logic [ADDR_W-1:0]     m_address;
  logic                  m_wr;
  logic                  m_busy;
  logic                  m_done;
  logic                  m_err;
  logic [NUM_SLAVES-1:0] s_sel;
  logic [WIN_BITS-1:0]   s_offset;
  logic                  s_wr;
  logic [NUM_SLAVES-1:0] s_ack;
  logic [CNT_W-1:0]      err_cnt;

  // Controller view.
  modport slave (
    input  m_req, m_address, m_wr, s_ack,
    output m_busy, m_done, m_err, s_sel, s_offset, s_wr, err_cnt
  );

  // Environment view: the requesting master plus the slave acks.
  modport master (
    output m_req, m_address, m_wr, s_ack,
    input  m_busy, m_done, m_err, s_sel, s_offset, s_wr, err_cnt
  );
endinterface

// File: rtl/bus_addr_ctrl_map.sv
// Combinational window decoder: splits the address into a slave index and
// reports whether that index lands on an existing slave.
module bus_addr_map
  import bus_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int WIN_BITS   = BUS_WIN_BITS,
  parameter int NUM_SLAVES = 2,
  localparam int IDX_W     = idx_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              hit_o
);
  localparam int HI_W = ADDR_W - WIN_BITS;

  logic [HI_W-1:0] hi;
  logic [31:0]     hi32;

  assign hi    = addr_i[ADDR_W-1:WIN_BITS];
  // Compare at 32 bits so a full map (NUM_SLAVES == 2^HI_W) still works.
  assign hi32  = 32'(hi);
  assign hit_o = hi32 < 32'(NUM_SLAVES);
  assign idx_o = IDX_W'(hi);

endmodule

// File: rtl/bus_addr_ctrl.sv
// Registered address decoder / access controller: one-hot slave select held
// until ack, with timeout and unmapped-address error completion.
module bus_addr_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int WIN_BITS   = BUS_WIN_BITS,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           reset,
  bus_addr_ctrl_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_SLAVES);
  localparam int TMR_W = idx_w(TIMEOUT);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WIN_BITS-1:0]   offset_q, offset_d;
  logic                  wr_q, wr_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic                  err_inc;

  logic [IDX_W-1:0]      map_idx;
  logic                  map_hit;

  bus_addr_map #(
    .ADDR_W     (ADDR_W),
    .WIN_BITS   (WIN_BITS),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_map (
    .addr_i (bus.m_address),
    .idx_o  (map_idx),
    .hit_o  (map_hit)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    offset_d = offset_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    timer_d  = timer_q;
    err_inc  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_req) begin
          if (map_hit) begin
            idx_d    = map_idx;
            offset_d = bus.m_address[WIN_BITS-1:0];
            wr_d     = bus.m_wr;
            sel_d    = NUM_SLAVES'(1) << map_idx;
            busy_d   = 1'b1;
            timer_d  = '0;
            state_d  = ST_ACCESS;
          end else begin
            // Unmapped: complete with error straight from IDLE.
            done_d  = 1'b1;
            err_d   = 1'b1;
            err_inc = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus.s_ack[idx_q]) begin
          done_d  = 1'b1;
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          err_inc = 1'b1;
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != {CNT_W{1'b1}})) ? err_cnt_q + 1'b1
                                                          : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      offset_q  <= '0;
      wr_q      <= 1'b0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      offset_q  <= offset_d;
      wr_q      <= wr_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.m_busy   = busy_q;
  assign bus.m_done   = done_q;
  assign bus.m_err    = err_q;
  assign bus.s_sel    = sel_q;
  assign bus.s_offset = offset_q;
  assign bus.s_wr     = wr_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bus_addr_ctrl.sv
// Scoreboard bench for bus_addr_ctrl: stimulus queues expected completions and
// output snapshots; a negedge monitor pops and compares them.
module tb_bus_addr_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_addr_ctrl_if #(.ADDR_W(8), .WIN_BITS(5), .NUM_SLAVES(2), .CNT_W(8)) bif ();

  bus_addr_ctrl #(
    .ADDR_W(8), .WIN_BITS(5), .NUM_SLAVES(2), .TIMEOUT(16), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    int   cyc;
    logic err;
    int   cnt;
  } done_t;

  typedef struct {
    int          cyc;
    string       nm;
    logic [1:0]  sel;
    logic        busy;
    logic [4:0]  off;
    logic        wr;
    int          cnt;
    bit          full;
  } snap_t;

  done_t dq[$];
  snap_t sq[$];
  done_t d;
  snap_t s;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  bit fin    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    if (bif.m_done) begin
      if (dq.size() == 0) cmp("unexpected_done", 1, 0);
      else begin
        d = dq.pop_front();
        cmp("done_cycle", cyc, d.cyc);
        cmp("done_err", int'(bif.m_err), int'(d.err));
        cmp("done_errcnt", int'(bif.err_cnt), d.cnt);
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      cmp({s.nm, "_cycle"}, cyc, s.cyc);
      cmp({s.nm, "_sel"}, int'(bif.s_sel), int'(s.sel));
      cmp({s.nm, "_busy"}, int'(bif.m_busy), int'(s.busy));
      cmp({s.nm, "_errcnt"}, int'(bif.err_cnt), s.cnt);
      if (s.full || s.sel != 2'b00) begin
        cmp({s.nm, "_offset"}, int'(bif.s_offset), int'(s.off));
        cmp({s.nm, "_wr"}, int'(bif.s_wr), int'(s.wr));
      end
      if (s.full) begin
        cmp({s.nm, "_done"}, int'(bif.m_done), 0);
        cmp({s.nm, "_err"}, int'(bif.m_err), 0);
      end
    end
    if (fin) begin
      cmp("pending_done", dq.size(), 0);
      cmp("pending_snap", sq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] a, input logic w);
    bif.m_req     = 1'b1;
    bif.m_address = a;
    bif.m_wr      = w;
  endtask

  task automatic expd(input int c, input logic err, input int cnt);
    dq.push_back('{cyc: c, err: err, cnt: cnt});
  endtask

  task automatic snap(input int c, input string nm, input logic [1:0] sel,
                      input logic busy, input logic [4:0] off, input logic wr,
                      input int cnt, input bit full);
    sq.push_back('{cyc: c, nm: nm, sel: sel, busy: busy, off: off, wr: wr,
                   cnt: cnt, full: full});
  endtask

  int c;

  initial begin
    bif.m_req = 1'b0; bif.m_address = '0; bif.m_wr = 1'b0; bif.s_ack = '0;
    step(); step();
    snap(cyc, "reset", 2'b00, 0, 5'h00, 0, 0, 1);
    reset = 1'b0;
    step(); step();

    // Slave 0 window top, ack two cycles after select rises.
    c = cyc;
    req(8'h1F, 0); expd(c + 4, 0, mcnt);
    step(); bif.m_req = 1'b0;
    snap(c + 1, "t1_sel", 2'b01, 1, 5'h1F, 0, mcnt, 0);
    step(); step();
    bif.s_ack = 2'b01;
    step(); bif.s_ack = 2'b00;
    snap(c + 4, "t1_end", 2'b00, 0, 5'h00, 0, mcnt, 0);
    step();

    // Write to slave 1 with immediate ack, back-to-back read in the done cycle.
    c = cyc;
    req(8'h2F, 1); expd(c + 2, 0, mcnt);
    step(); bif.m_req = 1'b0;
    snap(c + 1, "t2_sel", 2'b10, 1, 5'h0F, 1, mcnt, 0);
    bif.s_ack = 2'b10;
    step(); bif.s_ack = 2'b00;
    snap(c + 2, "t2_gap", 2'b00, 0, 5'h00, 0, mcnt, 0);
    req(8'h05, 0); expd(c + 4, 0, mcnt);
    step(); bif.m_req = 1'b0;
    snap(c + 3, "t2_b2b", 2'b01, 1, 5'h05, 0, mcnt, 0);
    bif.s_ack = 2'b01;
    step(); bif.s_ack = 2'b00;
    step();

    // Unmapped address.
    c = cyc;
    req(8'h55, 0); mcnt++; expd(c + 1, 1, mcnt);
    step(); bif.m_req = 1'b0;
    snap(c + 1, "t3_miss", 2'b00, 0, 5'h00, 0, mcnt, 0);
    step();

    // Timeout; wrong-slave ack and a request while busy are both ignored.
    c = cyc;
    req(8'h11, 0); expd(c + 17, 1, mcnt + 1);
    step(); bif.m_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      snap(c + i, "t4_sel", 2'b01, 1, 5'h11, 0, mcnt, 0);
      if (i == 4) bif.s_ack = 2'b10;
      if (i == 5) bif.s_ack = 2'b00;
      if (i == 8) req(8'h39, 1);
      if (i == 9) bif.m_req = 1'b0;
      step();
    end
    mcnt++;
    snap(c + 17, "t4_end", 2'b00, 0, 5'h00, 0, mcnt, 0);
    step();

    // Ack on the last allowed ACCESS cycle.
    c = cyc;
    req(8'h00, 0); expd(c + 17, 0, mcnt);
    step(); bif.m_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      snap(c + i, "t5_sel", 2'b01, 1, 5'h00, 0, mcnt, 0);
      if (i == 16) bif.s_ack = 2'b01;
      step();
    end
    bif.s_ack = 2'b00;
    snap(c + 17, "t5_end", 2'b00, 0, 5'h00, 0, mcnt, 0);
    step();

    // Reset in the middle of an access to slave 1.
    c = cyc;
    req(8'h20, 1);
    step(); bif.m_req = 1'b0;
    snap(c + 1, "t6_sel", 2'b10, 1, 5'h00, 1, mcnt, 0);
    step();
    reset = 1'b1;
    step(); reset = 1'b0; mcnt = 0;
    snap(c + 3, "t6_reset", 2'b00, 0, 5'h00, 0, 0, 1);
    step(); step();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      req(8'hFF, 0);
      mcnt = (mcnt < 255) ? mcnt + 1 : 255;
      expd(cyc + 1, 1, mcnt);
      step();
    end
    bif.m_req = 1'b0;
    snap(cyc, "t7_sat", 2'b00, 0, 5'h00, 0, 255, 0);
    step(); step();
    fin = 1'b1;
    step(); step();
  end

endmodule
